xdma_c2h_pkt_store_fwd: RTL and testbench
=========================================

// Module: xdma_c2h_pkt_store_fwd
// PURPOSE
//  Store-and-forward frame buffer on the CMAC/UDP RX -> XDMA C2H path (inverse of the H2C TX feed).
//  Always accepts 512-bit RX beats; CMAC RX cannot be back-pressured. Forwards only complete,
//  error-free frames to XDMA s_axis_c2h. Drops frames that are errored or overflow the buffer.
// PARAMETERS
//  DATA_W  512  AXIS tdata width
//  KEEP_W  64   AXIS tkeep width (DATA_W/8)
//  DEPTH   64   buffer depth in beats, power of 2, >=4; ADDR_W = $clog2(DEPTH)
// PORTS
//  xdma_clk         in   1       single clock (XDMA axi_aclk domain)
//  xdma_resetn      in   1       asynchronous, active-low reset
//  s_axis_tvalid    in   1       RX beat valid
//  s_axis_tready    out  1       1 whenever out of reset (never stalls)
//  s_axis_tdata     in   DATA_W  RX data
//  s_axis_tkeep     in   KEEP_W  RX byte enables
//  s_axis_tlast     in   1       last beat of frame
//  s_axis_tuser     in   1       frame error, sampled on tlast beat only
//  m_axis_tvalid    out  1       to XDMA C2H
//  m_axis_tready    in   1       from XDMA C2H
//  m_axis_tdata     out  DATA_W
//  m_axis_tkeep     out  KEEP_W
//  m_axis_tlast     out  1
//  drop_cnt         out  32      frames discarded; saturates at 2^32-1
// BEHAVIOUR
//  Reset: all pointers 0, state ACCEPT, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, drop_cnt=0.
//  Pointers wr_spec, wr_commit, rd are ADDR_W+1 bits; occupancy = wr_spec - rd (mod 2^(ADDR_W+1)).
//  Write FSM (per accepted beat, s_axis_tvalid & s_axis_tready):
//   ACCEPT, occupancy<DEPTH: write {tlast,tkeep,tdata} at wr_spec, wr_spec++.
//    tlast & !tuser: wr_commit <= wr_spec+1 (frame visible to read side).
//    tlast & tuser: wr_spec <= wr_commit, drop_cnt++.
//   ACCEPT, occupancy==DEPTH: wr_spec <= wr_commit, drop_cnt++; beat not tlast -> DROP; tlast -> stay.
//   DROP: discard beats; on tlast -> ACCEPT. No write, no count.
//  Frame longer than DEPTH beats: always dropped via the full rule.
//  Read side: beats at rd < wr_commit only. RAM read latency 1 -> 2-entry output skid register.
//   Latency: commit on cycle N -> m_axis_tvalid high at N+2 earliest; full throughput 1 beat/cycle.
//   AXIS rules: tvalid, once high, holds with stable data/keep/last until tready.
//   m_axis_tlast = stored tlast; tuser not forwarded (C2H port has none).
//  Simultaneous events: read and write same cycle legal; full check uses current-cycle rd (conservative).
//   Commit and rewind never coincide (mutually exclusive on one tlast beat).
//  Wrap-around: pointers wrap naturally; extra MSB distinguishes full from empty.
//  Reset mid-operation: all state cleared immediately; partial and committed frames lost;
//   m_axis_tvalid drops without handshake (XDMA is reset by the same signal).
// CONFIGURATION
//  XDMA_C2H_PKT_STATS_EN defined: adds outputs good_frame_cnt[31:0] (committed frames) and
//   max_occupancy[ADDR_W:0] (high-water mark). Both reset to 0; counter saturates.
//  Not defined: neither port exists and no logic is generated; drop_cnt is always present.
// STRUCTURE
//  Package xdma_c2h_pkg: DATA_W/KEEP_W defaults, entry width (DATA_W+KEEP_W+1),
//   write-FSM state enum {ST_ACCEPT, ST_DROP}.
//  Sub-module xdma_c2h_buf_ram: simple dual-port RAM, 1 write port, 1 registered read port,
//   DEPTH x (DATA_W+KEEP_W+1), inferred as URAM/BRAM.
//  Top: write FSM + pointers, read prefetch/skid logic, counters.
// TESTING
//  1 Good 3-beat frame, last tkeep=64'h0000_0000_0000_FFFF, m_tready=1 -> 3 beats out in order,
//    tkeep preserved, tlast on beat 3, first m_tvalid 2 cycles after input tlast.
//  2 4-beat frame with tuser=1 on tlast -> no output, drop_cnt=1; next good 1-beat frame passes.
//  3 DEPTH=16, m_tready=0: 10-beat frame then 10-beat frame -> 2nd dropped (drop_cnt=1);
//    then 4-beat frame -> committed; m_tready=1 -> 14 beats out (frame 1 then frame 3).
//  4 DEPTH=16: 17-beat frame -> dropped, drop_cnt=1, no output; FSM back in ACCEPT after tlast.
//  5 200 back-to-back 1-beat frames, m_tready toggling 1/0 -> all 200 out, in order, no drops.
//  6 Reset asserted while m_tvalid=1 -> m_tvalid=0 same cycle; after release, buffer empty,
//    drop_cnt=0, next frame passes.

Source files
------------

// File: rtl/xdma_c2h_pkg.sv
// Shared types and constants for the XDMA C2H store-and-forward frame buffer.
package xdma_c2h_pkg;

    localparam int C2H_DATA_W = 512;
    localparam int C2H_KEEP_W = C2H_DATA_W / 8;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_e;

    // Stored entry is {tlast, tkeep, tdata}.
    function automatic int entry_w(input int data_w, input int keep_w);
        return data_w + keep_w + 1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xdma_c2h_pkt_store_fwd_if.sv
// AXI4-Stream bundle used for both the CMAC RX input and the XDMA C2H output.
interface xdma_c2h_pkt_store_fwd_if
    import xdma_c2h_pkg::*;
#(
    parameter int DATA_W = C2H_DATA_W,
    parameter int KEEP_W = C2H_KEEP_W
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/xdma_c2h_buf_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module xdma_c2h_buf_ram #(
    parameter int  WIDTH  = 577,
    parameter int  DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array and read register carry no reset so they map onto URAM/BRAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/xdma_c2h_pkt_store_fwd.sv
// Store-and-forward RX frame buffer feeding XDMA C2H; only complete, error-free frames leave.
// Optional statistics outputs are enabled with `define XDMA_C2H_PKT_STATS_EN.
module xdma_c2h_pkt_store_fwd
    import xdma_c2h_pkg::*;
#(
    parameter int  DATA_W  = C2H_DATA_W,
    parameter int  KEEP_W  = C2H_KEEP_W,
    parameter int  DEPTH   = 64,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int ENTRY_W = entry_w(DATA_W, KEEP_W)
) (
    input  logic                      xdma_clk,
    input  logic                      xdma_resetn,
    xdma_c2h_pkt_store_fwd_if.slave   s_axis,
    xdma_c2h_pkt_store_fwd_if.master  m_axis,
`ifdef XDMA_C2H_PKT_STATS_EN
    output logic [31:0]               good_frame_cnt,
    output logic [ADDR_W:0]           max_occupancy,
`endif
    output logic [31:0]               drop_cnt
);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);

    wr_state_e          state_q;
    logic [ADDR_W:0]    wr_spec_q, wr_commit_q, rd_q;
    logic [31:0]        drop_cnt_q;
    logic               tready_q;
    logic [ADDR_W:0]    occ;
    logic               full, accept, ram_we, commit;

    logic               rvld_q, out_vld_q, sk_vld_q;
    logic [ENTRY_W-1:0] ram_rdata, out_q, sk_q;
    logic [1:0]         occupied;
    logic               pop, issue;

    assign occ    = wr_spec_q - rd_q;
    assign full   = (occ == FULL_OCC);
    assign accept = s_axis.tvalid & tready_q;
    assign ram_we = accept & (state_q == ST_ACCEPT) & ~full;
    assign commit = ram_we & s_axis.tlast & ~s_axis.tuser;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            state_q     <= ST_ACCEPT;
            wr_spec_q   <= '0;
            wr_commit_q <= '0;
            drop_cnt_q  <= '0;
            tready_q    <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            if (accept) begin
                case (state_q)
                    ST_ACCEPT: begin
                        if (full) begin
                            wr_spec_q  <= wr_commit_q;
                            drop_cnt_q <= sat_inc32(drop_cnt_q);
                            if (!s_axis.tlast) state_q <= ST_DROP;
                        end else if (s_axis.tlast && s_axis.tuser) begin
                            wr_spec_q  <= wr_commit_q;
                            drop_cnt_q <= sat_inc32(drop_cnt_q);
                        end else begin
                            wr_spec_q <= wr_spec_q + PTR_ONE;
                            if (commit) wr_commit_q <= wr_spec_q + PTR_ONE;
                        end
                    end
                    ST_DROP: begin
                        if (s_axis.tlast) state_q <= ST_ACCEPT;
                    end
                endcase
            end
        end
    end

    xdma_c2h_buf_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (xdma_clk),
        .we_i    (ram_we),
        .waddr_i (wr_spec_q[ADDR_W-1:0]),
        .wdata_i ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
        .re_i    (issue),
        .raddr_i (rd_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // Reads in flight plus held beats never exceed the two skid slots.
    assign occupied = {1'b0, out_vld_q} + {1'b0, sk_vld_q} + {1'b0, rvld_q};
    assign pop      = out_vld_q & m_axis.tready;
    assign issue    = (rd_q != wr_commit_q) && ((occupied < 2'd2) || pop);

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            rd_q      <= '0;
            rvld_q    <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            sk_vld_q  <= 1'b0;
            sk_q      <= '0;
        end else begin
            rvld_q <= issue;
            if (issue) rd_q <= rd_q + PTR_ONE;
            if (!out_vld_q || pop) begin
                if (sk_vld_q) begin
                    out_q     <= sk_q;
                    out_vld_q <= 1'b1;
                    sk_vld_q  <= rvld_q;
                    if (rvld_q) sk_q <= ram_rdata;
                end else begin
                    out_vld_q <= rvld_q;
                    if (rvld_q) out_q <= ram_rdata;
                end
            end else if (rvld_q) begin
                sk_vld_q <= 1'b1;
                sk_q     <= ram_rdata;
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = out_vld_q;
    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_q;
    assign m_axis.tuser  = 1'b0;
    assign drop_cnt      = drop_cnt_q;

`ifdef XDMA_C2H_PKT_STATS_EN
    logic [31:0]     good_cnt_q;
    logic [ADDR_W:0] max_occ_q;

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            good_cnt_q <= '0;
            max_occ_q  <= '0;
        end else begin
            if (commit) good_cnt_q <= sat_inc32(good_cnt_q);
            if (occ > max_occ_q) max_occ_q <= occ;
        end
    end

    assign good_frame_cnt = good_cnt_q;
    assign max_occupancy  = max_occ_q;
`endif

endmodule

// File: tb/tb_xdma_c2h_pkt_store_fwd.sv
// Directed self-checking bench for xdma_c2h_pkt_store_fwd (DEPTH=16 build).
`timescale 1ns/1ps
module tb_xdma_c2h_pkt_store_fwd;
    import xdma_c2h_pkg::*;

    localparam int DATA_W = C2H_DATA_W;
    localparam int KEEP_W = C2H_KEEP_W;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic        xdma_clk    = 1'b0;
    logic        xdma_resetn = 1'b0;
    logic [31:0] drop_cnt;
`ifdef XDMA_C2H_PKT_STATS_EN
    logic [31:0]           good_frame_cnt;
    logic [$clog2(DEPTH):0] max_occupancy;
`endif

    xdma_c2h_pkt_store_fwd_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) s_axis ();
    xdma_c2h_pkt_store_fwd_if #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) m_axis ();

    xdma_c2h_pkt_store_fwd #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .DEPTH  (DEPTH)
    ) dut (
        .xdma_clk       (xdma_clk),
        .xdma_resetn    (xdma_resetn),
        .s_axis         (s_axis),
        .m_axis         (m_axis),
`ifdef XDMA_C2H_PKT_STATS_EN
        .good_frame_cnt (good_frame_cnt),
        .max_occupancy  (max_occupancy),
`endif
        .drop_cnt       (drop_cnt)
    );

    always #5 xdma_clk = ~xdma_clk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t rx_q[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshakes and checks AXIS hold-while-stalled.
    logic  stall_pend = 1'b0;
    beat_t held;
    always @(negedge xdma_clk) begin
        if (!xdma_resetn) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", 512'(m_axis.tvalid), 512'(1));
                check("stall_data", m_axis.tdata, held.data);
                check("stall_ctl", 512'({m_axis.tkeep, m_axis.tlast}), 512'({held.keep, held.last}));
            end
            if (m_axis.tvalid && m_axis.tready)
                rx_q.push_back('{data: m_axis.tdata, keep: m_axis.tkeep, last: m_axis.tlast});
            stall_pend = m_axis.tvalid & ~m_axis.tready;
            held       = '{data: m_axis.tdata, keep: m_axis.tkeep, last: m_axis.tlast};
        end
    end

    function automatic logic [DATA_W-1:0] make_data(input logic [31:0] v);
        return {16{v}};
    endfunction

    task automatic tick();
        @(posedge xdma_clk);
        #1;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                             input logic l, input logic u);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        tick();
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int nbeats,
                              input logic [KEEP_W-1:0] last_keep, input logic err, input logic expect_out);
        for (int i = 0; i < nbeats; i++) begin
            logic              l;
            logic [KEEP_W-1:0] k;
            l = (i == nbeats - 1);
            k = l ? last_keep : {KEEP_W{1'b1}};
            send_beat(make_data(base + 32'(i)), k, l, l & err);
            if (expect_out) exp_q.push_back('{data: make_data(base + 32'(i)), keep: k, last: l});
        end
    endtask

    task automatic do_reset();
        xdma_resetn   = 1'b0;
        s_axis.tvalid = 1'b0;
        m_axis.tready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rx_q.delete();
        xdma_resetn = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag, input int budget);
        int    n;
        beat_t e, r;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check({tag, "_count"}, 512'(rx_q.size()), 512'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            check({tag, "_data"}, r.data, e.data);
            check({tag, "_keep_last"}, 512'({r.keep, r.last}), 512'({e.keep, e.last}));
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        m_axis.tready = 1'b0;

        // Reset values
        #12;
        check("rst_s_tready", 512'(s_axis.tready), 512'(0));
        check("rst_m_tvalid", 512'(m_axis.tvalid), 512'(0));
        check("rst_m_tdata", m_axis.tdata, 512'(0));
        check("rst_m_ctl", 512'({m_axis.tkeep, m_axis.tlast}), 512'(0));
        check("rst_drop_cnt", 512'(drop_cnt), 512'(0));
        @(posedge xdma_clk);
        #1;
        xdma_resetn = 1'b1;
        tick();
        check("s_tready_up", 512'(s_axis.tready), 512'(1));

        // 1: good 3-beat frame, partial keep on last, tuser ignored off the tlast beat
        m_axis.tready = 1'b1;
        send_beat(make_data(32'h100), {KEEP_W{1'b1}}, 1'b0, 1'b1);
        send_beat(make_data(32'h101), {KEEP_W{1'b1}}, 1'b0, 1'b0);
        send_beat(make_data(32'h102), 64'h0000_0000_0000_FFFF, 1'b1, 1'b0);
        exp_q.push_back('{data: make_data(32'h100), keep: {KEEP_W{1'b1}}, last: 1'b0});
        exp_q.push_back('{data: make_data(32'h101), keep: {KEEP_W{1'b1}}, last: 1'b0});
        exp_q.push_back('{data: make_data(32'h102), keep: 64'h0000_0000_0000_FFFF, last: 1'b1});
        check("t1_lat0", 512'(m_axis.tvalid), 512'(0));
        tick();
        check("t1_lat1", 512'(m_axis.tvalid), 512'(0));
        tick();
        check("t1_lat2", 512'(m_axis.tvalid), 512'(1));
        drain("t1", 20);
        check("t1_drop", 512'(drop_cnt), 512'(0));

        // 2: errored 4-beat frame dropped, next 1-beat frame passes
        do_reset();
        m_axis.tready = 1'b1;
        send_frame(32'h200, 4, {KEEP_W{1'b1}}, 1'b1, 1'b0);
        repeat (5) tick();
        check("t2_drop", 512'(drop_cnt), 512'(1));
        send_frame(32'h210, 1, 64'h0000_0000_0000_00FF, 1'b0, 1'b1);
        drain("t2", 20);

        // 3: overflow of second frame while output stalled
        do_reset();
        m_axis.tready = 1'b0;
        send_frame(32'h300, 10, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        send_frame(32'h320, 10, {KEEP_W{1'b1}}, 1'b0, 1'b0);
        send_frame(32'h340, 4, 64'h0000_0000_0000_000F, 1'b0, 1'b1);
        repeat (3) tick();
        check("t3_drop", 512'(drop_cnt), 512'(1));
        check("t3_stalled_valid", 512'(m_axis.tvalid), 512'(1));
        m_axis.tready = 1'b1;
        drain("t3", 60);

        // 4: exactly DEPTH beats fits; DEPTH+1 and longer frames are dropped
        do_reset();
        m_axis.tready = 1'b1;
        send_frame(32'h400, 16, 64'h0000_0000_0000_0003, 1'b0, 1'b1);
        drain("t4_fit", 40);
        send_frame(32'h420, 17, {KEEP_W{1'b1}}, 1'b0, 1'b0);
        repeat (3) tick();
        check("t4_drop17", 512'(drop_cnt), 512'(1));
        drain("t4_none", 5);
        send_frame(32'h440, 20, {KEEP_W{1'b1}}, 1'b0, 1'b0);
        send_frame(32'h460, 2, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        drain("t4_after", 20);
        check("t4_drop20", 512'(drop_cnt), 512'(2));

        // 5: 200 one-beat frames with output ready toggling
        do_reset();
        for (int i = 0; i < 200; i++) begin
            logic [KEEP_W-1:0] k;
            k = {KEEP_W{1'b1}} >> (i % 64);
            m_axis.tready = 1'b1;
            send_beat(make_data(32'h5000 + 32'(i)), k, 1'b1, 1'b0);
            exp_q.push_back('{data: make_data(32'h5000 + 32'(i)), keep: k, last: 1'b1});
            m_axis.tready = 1'b0;
            tick();
        end
        m_axis.tready = 1'b1;
        drain("t5", 100);
        check("t5_drop", 512'(drop_cnt), 512'(0));

        // 6: reset while output valid
        do_reset();
        m_axis.tready = 1'b1;
        send_frame(32'h600, 3, {KEEP_W{1'b1}}, 1'b1, 1'b0);
        tick();
        check("t6_pre_drop", 512'(drop_cnt), 512'(1));
        m_axis.tready = 1'b0;
        send_frame(32'h610, 2, {KEEP_W{1'b1}}, 1'b0, 1'b0);
        repeat (3) tick();
        check("t6_valid_before", 512'(m_axis.tvalid), 512'(1));
        #2;
        xdma_resetn = 1'b0;
        #1;
        check("t6_valid_async", 512'(m_axis.tvalid), 512'(0));
        check("t6_drop_clr", 512'(drop_cnt), 512'(0));
        check("t6_tdata_clr", m_axis.tdata, 512'(0));
        tick();
        exp_q.delete();
        rx_q.delete();
        xdma_resetn = 1'b1;
        tick();
        m_axis.tready = 1'b1;
        repeat (6) tick();
        drain("t6_empty", 5);
        send_frame(32'h620, 1, 64'h0000_0000_0000_0001, 1'b0, 1'b1);
        drain("t6_after", 20);
        check("t6_drop_after", 512'(drop_cnt), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
